// File: rtl/audio_sample_interp.sv
// audio_sample_interp
//   Stereo sample FIFO plus linear interpolator feeding the stereo DAC.
//   Each accepted pair becomes the target of a 2^STEP_SHIFT-clock linear
//   ramp. Both channels share one FIFO, state and counter, so they move in
//   lockstep.
//
// Optional build macro: AUDIO_INTERP_MUTE_EN (adds the mute input).
//
// Ports:
//   clk       system clock
//   reset     synchronous active-high reset
//   in_l/in_r signed 16-bit input sample pair
//   in_valid  sample pair present
//   in_ready  FIFO not full (registered)
//   d_l/d_r   offset-binary outputs to the DAC (registered)
//   level     FIFO occupancy
//   underrun  one-cycle pulse: ramp finished with FIFO empty
//   mute      (AUDIO_INTERP_MUTE_EN only) force loaded targets to midscale
//
// state  | meaning
// IDLE   | no sample loaded since reset
// RAMP   | stepping accumulators toward the current target
// HOLD   | ramp done, FIFO was empty, output frozen at target
module audio_sample_interp #(
  parameter int DEPTH      = 4,
  parameter int STEP_SHIFT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              in_l,
  input  logic [15:0]              in_r,
  input  logic                     in_valid,
`ifdef AUDIO_INTERP_MUTE_EN
  input  logic                     mute,
`endif
  output logic                     in_ready,
  output logic [15:0]              d_l,
  output logic [15:0]              d_r,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun
);
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int ACCW = 16 + STEP_SHIFT;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RAMP = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [31:0]            r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]          r_level;
  logic                   r_in_ready;
  logic                   r_underrun;
  logic [1:0]             r_state;
  logic [STEP_SHIFT-1:0]  r_cnt;
  logic signed [ACCW-1:0] r_acc_l, r_acc_r;
  logic signed [16:0]     r_delta_l, r_delta_r;
  logic [15:0]            r_tgt_l, r_tgt_r;
  logic [15:0]            r_d_l, r_d_r;

  logic                   w_push, w_pop, w_last;
  logic [LW-1:0]          w_level_nxt;
  logic [15:0]            w_new_l, w_new_r;
  logic signed [16:0]     w_delta_l, w_delta_r;
  logic signed [ACCW-1:0] w_acc_l_nxt, w_acc_r_nxt;

  assign w_push      = in_valid & r_in_ready;
  assign w_last      = (r_cnt == {STEP_SHIFT{1'b1}});
  // Pop only when idle/holding, or on the final step of a ramp so the next
  // ramp starts with no gap.
  assign w_pop       = (r_level != '0) && ((r_state != S_RAMP) || w_last);
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

`ifdef AUDIO_INTERP_MUTE_EN
  assign w_new_l = mute ? 16'h0000 : r_mem[r_rd_ptr][31:16];
  assign w_new_r = mute ? 16'h0000 : r_mem[r_rd_ptr][15:0];
`else
  assign w_new_l = r_mem[r_rd_ptr][31:16];
  assign w_new_r = r_mem[r_rd_ptr][15:0];
`endif

  // The current integer value at a load is always the previous target:
  // 0 after reset, or the exact endpoint reached by the finished ramp.
  assign w_delta_l = $signed({w_new_l[15], w_new_l}) - $signed({r_tgt_l[15], r_tgt_l});
  assign w_delta_r = $signed({w_new_r[15], w_new_r}) - $signed({r_tgt_r[15], r_tgt_r});

  always_comb begin
    w_acc_l_nxt = r_acc_l;
    w_acc_r_nxt = r_acc_r;
    if (w_pop) begin
      w_acc_l_nxt = $signed({r_tgt_l, {STEP_SHIFT{1'b0}}});
      w_acc_r_nxt = $signed({r_tgt_r, {STEP_SHIFT{1'b0}}});
    end else if (r_state == S_RAMP) begin
      // Adding delta 2^STEP_SHIFT times lands exactly on {target, 0}.
      w_acc_l_nxt = r_acc_l + ACCW'(r_delta_l);
      w_acc_r_nxt = r_acc_r + ACCW'(r_delta_r);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= {in_l, in_r};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_in_ready <= 1'b1;
      r_underrun <= 1'b0;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc_l    <= '0;
      r_acc_r    <= '0;
      r_delta_l  <= '0;
      r_delta_r  <= '0;
      r_tgt_l    <= '0;
      r_tgt_r    <= '0;
      r_d_l      <= 16'h8000;
      r_d_r      <= 16'h8000;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level    <= w_level_nxt;
      r_in_ready <= (w_level_nxt != LW'(DEPTH));
      r_underrun <= (r_state == S_RAMP) && w_last && !w_pop;
      r_acc_l    <= w_acc_l_nxt;
      r_acc_r    <= w_acc_r_nxt;
      r_d_l      <= w_acc_l_nxt[ACCW-1 -: 16] ^ 16'h8000;
      r_d_r      <= w_acc_r_nxt[ACCW-1 -: 16] ^ 16'h8000;
      if (w_pop) begin
        r_state   <= S_RAMP;
        r_cnt     <= '0;
        r_delta_l <= w_delta_l;
        r_delta_r <= w_delta_r;
        r_tgt_l   <= w_new_l;
        r_tgt_r   <= w_new_r;
      end else if (r_state == S_RAMP) begin
        r_cnt <= r_cnt + STEP_SHIFT'(1);
        if (w_last) r_state <= S_HOLD;
      end
    end
  end

  assign in_ready = r_in_ready;
  assign d_l      = r_d_l;
  assign d_r      = r_d_r;
  assign level    = r_level;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_audio_sample_interp.sv
module tb_audio_sample_interp;
  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam int N     = 1 << SS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_l = '0, in_r = '0;
  logic        in_valid = 1'b0;
  logic        mute_drv = 1'b0;
  logic        in_ready;
  logic [15:0] d_l, d_r;
  logic [2:0]  level;
  logic        underrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  audio_sample_interp #(.DEPTH(DEPTH), .STEP_SHIFT(SS)) dut (
    .clk(clk), .reset(reset), .in_l(in_l), .in_r(in_r), .in_valid(in_valid),
`ifdef AUDIO_INTERP_MUTE_EN
    .mute(mute_drv),
`endif
    .in_ready(in_ready), .d_l(d_l), .d_r(d_r), .level(level), .underrun(underrun)
  );

  // Reference model: a queue of pending pairs and, per channel, the current
  // ramp's start and end points plus how many steps have been taken.
  int mq_l[$], mq_r[$];
  int m_mode;             // 0 idle, 1 ramping, 2 holding
  int m_k;
  int m_pl, m_pr, m_tl, m_tr;
  bit m_ready = 1'b1, m_under = 1'b0;

  function automatic logic [15:0] interp(int p, int t, int k);
    int v;
    v = p * N + (t - p) * k;
    v = v >>> SS;
    return 16'(v) ^ 16'h8000;
  endfunction

  task automatic model_step(bit rst, bit vld, logic [15:0] l, logic [15:0] r, bit mt);
    bit push, done;
    int vl, vr;
    if (rst) begin
      mq_l.delete(); mq_r.delete();
      m_mode = 0; m_k = 0; m_pl = 0; m_pr = 0; m_tl = 0; m_tr = 0;
      m_ready = 1'b1; m_under = 1'b0;
      return;
    end
    push = vld && m_ready;
    done = 1'b0;
    m_under = 1'b0;
    if (m_mode == 1) begin
      m_k++;
      if (m_k == N) done = 1'b1;
    end
    if (mq_l.size() > 0 && (m_mode != 1 || done)) begin
      vl = mq_l.pop_front();
      vr = mq_r.pop_front();
      m_pl = m_tl; m_pr = m_tr;
      m_tl = mt ? 0 : vl;
      m_tr = mt ? 0 : vr;
      m_k = 0; m_mode = 1;
    end else if (done) begin
      m_pl = m_tl; m_pr = m_tr; m_k = 0; m_mode = 2; m_under = 1'b1;
    end
    if (push) begin
      mq_l.push_back(int'($signed(l)));
      mq_r.push_back(int'($signed(r)));
    end
    m_ready = (mq_l.size() != DEPTH);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_d_l", 32'(d_l), 32'(interp(m_pl, m_tl, m_k)));
    check("model_d_r", 32'(d_r), 32'(interp(m_pr, m_tr, m_k)));
    check("model_ready", 32'(in_ready), 32'(m_ready));
    check("model_level", 32'(level), 32'(mq_l.size()));
    check("model_underrun", 32'(underrun), 32'(m_under));
  endtask

  task automatic cyc(bit rst, bit vld, logic [15:0] l, logic [15:0] r);
    bit mt;
    mt = 1'b0;
`ifdef AUDIO_INTERP_MUTE_EN
    mt = mute_drv;
`endif
    reset = rst; in_valid = vld; in_l = l; in_r = r;
    @(posedge clk);
    model_step(rst, vld, l, r, mt);
    #1;
    check_model();
  endtask

  typedef struct {
    bit rst; bit vld; logic [15:0] l; logic [15:0] r;
    logic [15:0] edl; logic [15:0] edr; bit erdy; int elvl; bit eund;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [15:0] exp_seq[4];
    logic [15:0] s_l[6], s_r[6];
    int und_cnt;
    bit seen, acc;

    tbl[0] = '{1, 0, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 1, 0, 0};
    tbl[1] = '{0, 1, 16'h0400, 16'hFC00, 16'h8000, 16'h8000, 1, 1, 0};
    tbl[2] = '{0, 0, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 1, 0, 0};
    tbl[3] = '{0, 0, 16'h0000, 16'h0000, 16'h8100, 16'h7F00, 1, 0, 0};
    tbl[4] = '{0, 0, 16'h0000, 16'h0000, 16'h8200, 16'h7E00, 1, 0, 0};
    tbl[5] = '{0, 0, 16'h0000, 16'h0000, 16'h8300, 16'h7D00, 1, 0, 0};
    tbl[6] = '{0, 0, 16'h0000, 16'h0000, 16'h8400, 16'h7C00, 1, 0, 1};
    tbl[7] = '{0, 0, 16'h0000, 16'h0000, 16'h8400, 16'h7C00, 1, 0, 0};

    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].rst, tbl[i].vld, tbl[i].l, tbl[i].r);
      check("tbl_d_l", 32'(d_l), 32'(tbl[i].edl));
      check("tbl_d_r", 32'(d_r), 32'(tbl[i].edr));
      check("tbl_ready", 32'(in_ready), 32'(tbl[i].erdy));
      check("tbl_level", 32'(level), 32'(tbl[i].elvl));
      check("tbl_underrun", 32'(underrun), 32'(tbl[i].eund));
    end

    // Downward ramp from 0x0400 to 0xFC00, then full-scale extremes.
    exp_seq = '{16'h8200, 16'h8000, 16'h7E00, 16'h7C00};
    cyc(0, 1, 16'hFC00, 16'hFC00);
    cyc(0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 16'h0, 16'h0);
      check("down_ramp_d_l", 32'(d_l), 32'(exp_seq[i]));
    end
    cyc(0, 1, 16'h7FFF, 16'h0000);
    for (int i = 0; i < 5; i++) cyc(0, 0, 16'h0, 16'h0);
    check("max_d_l", 32'(d_l), 32'h0000FFFF);
    cyc(0, 1, 16'h8000, 16'h0000);
    for (int i = 0; i < 5; i++) cyc(0, 0, 16'h0, 16'h0);
    check("min_d_l", 32'(d_l), 32'h00000000);

    // Six back-to-back pushes from IDLE.
    cyc(1, 0, 16'h0, 16'h0);
    for (int i = 0; i < 6; i++) begin
      s_l[i] = 16'(16'h0800 * (i + 1));
      s_r[i] = 16'(16'hF000 - 16'h0300 * i);
    end
    for (int i = 0; i < 6; i++) begin
      acc = 1'b0;
      for (int w = 0; w < 40 && !acc; w++) begin
        acc = m_ready;
        cyc(0, 1, s_l[i], s_r[i]);
        if (level == 3'd4) check("full_ready_low", 32'(in_ready), 32'h0);
      end
      if (!acc) check("push_accept_timeout", 32'h0, 32'h1);
    end
    und_cnt = 0;
    seen = 1'b0;
    for (int w = 0; w < 100 && !seen; w++) begin
      cyc(0, 0, 16'h0, 16'h0);
      if (underrun) begin und_cnt++; seen = 1'b1; end
    end
    check("drain_underrun_seen", 32'(seen), 32'h1);
    check("drain_final_d_l", 32'(d_l), 32'(s_l[5] ^ 16'h8000));
    check("drain_final_d_r", 32'(d_r), 32'(s_r[5] ^ 16'h8000));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 16'h0, 16'h0);
      check("hold_no_underrun", 32'(underrun), 32'h0);
      check("hold_d_l", 32'(d_l), 32'(s_l[5] ^ 16'h8000));
    end
    // Resume from HOLD: d unchanged one edge after acceptance, moves at two.
    cyc(0, 1, 16'h0000, 16'h0000);
    cyc(0, 0, 16'h0, 16'h0);
    check("resume_t1_d_l", 32'(d_l), 32'(s_l[5] ^ 16'h8000));
    cyc(0, 0, 16'h0, 16'h0);
    check("resume_t2_d_l", 32'(d_l), 32'((s_l[5] - (s_l[5] >> 2)) ^ 16'h8000));

    // Reset mid-ramp with three samples queued.
    cyc(1, 0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 16'(16'h1000 * (i + 1)), 16'h2222);
    check("pre_reset_level", 32'(level), 32'h3);
    cyc(1, 1, 16'h7777, 16'h7777);
    check("rst_d_l", 32'(d_l), 32'h8000);
    check("rst_d_r", 32'(d_r), 32'h8000);
    check("rst_level", 32'(level), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);
    cyc(0, 0, 16'h0, 16'h0);
    cyc(0, 0, 16'h0, 16'h0);
    check("rst_idle_d_l", 32'(d_l), 32'h8000);
    check("rst_idle_level", 32'(level), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
`ifdef AUDIO_INTERP_MUTE_EN
      if ($urandom_range(0, 19) == 0) mute_drv = ~mute_drv;
`endif
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 9) < (i % 400 < 200 ? 8 : 2),
          16'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/audio_sample_interp.md
Name: audio_sample_interp

Overview:
- Stereo sample buffer and linear interpolator directly upstream of the stereo hybrid PWM/sigma-delta DAC.
- Accepts signed 16-bit stereo samples at audio rate through a valid/ready handshake and buffers them in a small FIFO.
- Ramps each channel linearly from the previous sample to the next over 2^STEP_SHIFT clocks.
- Presents unsigned offset-binary d_l/d_r every clock, suppressing the zero-order-hold images the DAC would otherwise reproduce.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- STEP_SHIFT, 8, log2 of clocks per interpolation ramp (1..12)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- in_l  input  16  left sample, two's complement
- in_r  input  16  right sample, two's complement
- in_valid  input  1  sample pair present
- in_ready  output  1  FIFO not full; registered
- d_l  output  16  left to DAC, offset binary (signed XOR 0x8000)
- d_r  output  16  right to DAC, offset binary
- level  output  $clog2(DEPTH)+1  FIFO occupancy
- underrun  output  1  one-cycle pulse: ramp finished with FIFO empty

Behaviour:
- Reset:
  - FIFO empty, level=0, in_ready=1, underrun=0.
  - Accumulators 0, so d_l=d_r=0x8000.
  - State IDLE.
- Push:
  - in_valid&in_ready at an edge writes the pair and increments level.
  - in_ready = (level != DEPTH), registered.
  - Write while full is impossible by construction.
- Pop/push in the same cycle: level unchanged, both occur.
- States:
  - IDLE: no sample ever loaded. FIFO non-empty -> pop, load, go RAMP.
  - RAMP: each edge acc += delta and cnt++. On the edge where cnt reaches 2^STEP_SHIFT-1:
    - FIFO non-empty: pop and load, stay RAMP. Seamless, no idle cycle.
    - FIFO empty: go HOLD and pulse underrun for one cycle.
  - HOLD: output frozen at the last target. FIFO non-empty -> pop, load, RAMP.
- Load (per channel):
  - delta = sext17(target) - sext17(current integer value). Range -65535..65535, 17-bit signed.
  - acc = {current, STEP_SHIFT'b0}; cnt = 0.
- Accumulator:
  - Signed, 16+STEP_SHIFT bits.
  - Its trajectory lies between the endpoints, so no overflow.
  - After exactly 2^STEP_SHIFT increments acc == {target, 0}. No rounding drift is permitted.
- Output: d = acc[top 16 bits] XOR 0x8000, registered; updates on the same edge as acc.
- Latency:
  - Pair accepted at edge t from IDLE/HOLD: popped/loaded at edge t+1.
  - d first moves at edge t+2.
  - d equals target after edge t+1+2^STEP_SHIFT.
- Both channels share state, counter and FIFO; left and right always move in lockstep.
- Reset asserted mid-ramp: everything returns to reset values on that edge. Buffered samples are discarded, and in_valid is ignored on that edge.

Optional Feature:
- Macro AUDIO_INTERP_MUTE_EN.
- Defined:
  - Adds input port mute (1 bit).
  - At each load, if mute=1 both targets are forced to 0 (midscale), so the output glides to silence without clicks.
  - The popped sample is still consumed; FIFO flow is unchanged.
  - Clearing mute ramps back from the next loaded sample.
- Undefined: no mute port; targets are always the popped samples.

Test Plan:
- STEP_SHIFT=2, after reset push (0x0400,0xFC00) -> d_l 0x8100,0x8200,0x8300,0x8400 and d_r 0x7F00,0x7E00,0x7D00,0x7C00 on edges t+2..t+5; underrun pulses at t+5.
- From 0x0400, push 0xFC00 (left) -> d_l 0x8200,0x8000,0x7E00,0x7C00; then push 0x7FFF followed by 0x8000 -> final d_l 0xFFFF then exactly 0x0000, no overflow.
- DEPTH=4, six back-to-back pushes from IDLE -> first popped at t+1, in_ready=0 once level=4, no sample lost or duplicated, ramps contiguous with no HOLD cycles.
- FIFO drained -> underrun is a single-cycle pulse, d held constant in HOLD; a later push resumes the ramp two edges after acceptance.
- Reset asserted mid-ramp with level=3 -> next cycle d=0x8000, level=0, in_ready=1, state IDLE.
- AUDIO_INTERP_MUTE_EN, mute=1 while at 0x8400 with a queued sample -> ramps to 0x8000 over 2^STEP_SHIFT clocks, sample consumed (level decrements).
